// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM round-robin arbiter.
package sram_arb_pkg;

    localparam int MAX_REQ     = 4;
    localparam int ID_W        = $clog2(MAX_REQ);
    // The stage-1 struct is sized from these; the top defaults to the same widths.
    localparam int SRAM_DATA_W = 128;
    localparam int SRAM_ADDR_W = 10;

    typedef struct packed {
        logic                   valid;
        logic                   write;
        logic [ID_W-1:0]        id;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } s1_cmd_t;

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr+1 upward with wrap, one-hot grant.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-read SRAM between NUM_REQ requesters.
// Optional per-requester grant counters when SRAM_ARB_STATS_EN is defined.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_W,
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          sram_wen,
    output logic [ADDR_WIDTH-1:0]         sram_wadr,
    output logic [DATA_WIDTH-1:0]         sram_wdata,
    output logic                          sram_ren,
    output logic [ADDR_WIDTH-1:0]         sram_radr,
`ifdef SRAM_ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
    input  logic [DATA_WIDTH-1:0]         sram_rdata
);

    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic [ID_W-1:0]       win_id;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    s1_cmd_t               s1;
    logic                  s2_valid;
    logic [ID_W-1:0]       s2_id;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        win_id    = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_id    = ID_W'(i);
                win_write = req_write[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            s1       <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
        end else begin
            s1.valid <= accept;
            if (accept) begin
                rr_ptr   <= win_id;
                s1.write <= win_write;
                s1.id    <= win_id;
                s1.addr  <= win_addr;
                if (win_write) s1.wdata <= win_wdata;
            end
            s2_valid <= s1.valid & ~s1.write;
            s2_id    <= s1.id;
        end
    end

    assign sram_wen   = s1.valid & s1.write;
    assign sram_ren   = s1.valid & ~s1.write;
    assign sram_wadr  = s1.addr;
    assign sram_radr  = s1.addr;
    assign sram_wdata = s1.wdata;

    // Read data is gated so idle cycles never expose the SRAM output.
    assign resp_rdata = s2_valid ? sram_rdata : '0;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s2_valid && s2_id == ID_W'(i)) resp_valid[i] = 1'b1;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, acceptance-order reference model, directed and random scenarios.
module tb_sram_arbiter;

    localparam int NR = 2;
    localparam int DW = 128;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              sram_wen;
    logic [AW-1:0]     sram_wadr;
    logic [DW-1:0]     sram_wdata;
    logic              sram_ren;
    logic [AW-1:0]     sram_radr;
    logic [DW-1:0]     sram_rdata = '0;
`ifdef SRAM_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [NR*16-1:0]  grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_wen(sram_wen), .sram_wadr(sram_wadr), .sram_wdata(sram_wdata),
        .sram_ren(sram_ren), .sram_radr(sram_radr),
`ifdef SRAM_ARB_STATS_EN
        .stats_clr(stats_clr), .grant_cnt(grant_cnt),
`endif
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: write on edge, registered 1-cycle read (read-old on collision).
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_wen) mem[sram_wadr] <= sram_wdata;
        if (sram_ren) sram_rdata <= mem[sram_radr];
    end

    // Reference model: memory contents in acceptance order, expected responses by due cycle.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    exp_t          rq[$];
    int            m_last;
    int            cyc;
    logic          s1_v, s1_w;
    logic [AW-1:0] s1_a;
    logic [DW-1:0] s1_d;

    function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int last);
        logic [NR-1:0] g = '0;
        for (int k = 1; k <= NR; k++) begin
            int idx = (last + k) % NR;
            if (v[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_last = NR - 1;
        rq.delete();
        s1_v = 1'b0;
        s1_w = 1'b0;
        s1_a = '0;
        s1_d = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: score outputs at the negedge, advance the model, return at posedge+1.
    task automatic tick();
        logic [NR-1:0] g;
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        exp_t          e;
        @(negedge clk);
        g = model_grant(req_valid, m_last);
        checks++;
        if (req_ready !== g) begin
            errors++;
            $display("FAIL grant cyc=%0d: req_ready=%b expected %b", cyc, req_ready, g);
        end
        checks++;
        if (sram_wen !== (s1_v & s1_w) || sram_ren !== (s1_v & ~s1_w)) begin
            errors++;
            $display("FAIL sram_en cyc=%0d: wen=%b ren=%b expected wen=%b ren=%b", cyc, sram_wen, sram_ren, s1_v & s1_w, s1_v & ~s1_w);
        end
        if (s1_v) begin
            checks++;
            if (s1_w && (sram_wadr !== s1_a || sram_wdata !== s1_d)) begin
                errors++;
                $display("FAIL sram_write cyc=%0d: wadr=%0d wdata=%h expected %0d %h", cyc, sram_wadr, sram_wdata, s1_a, s1_d);
            end else if (!s1_w && sram_radr !== s1_a) begin
                errors++;
                $display("FAIL sram_read cyc=%0d: radr=%0d expected %0d", cyc, sram_radr, s1_a);
            end
        end
        ev = '0;
        ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            ev[e.id] = 1'b1;
            ed = e.data;
        end
        checks++;
        if (resp_valid !== ev || resp_rdata !== ed) begin
            errors++;
            $display("FAIL resp cyc=%0d: resp_valid=%b rdata=%h expected %b %h", cyc, resp_valid, resp_rdata, ev, ed);
        end
        s1_v = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                m_last = i;
                s1_v   = 1'b1;
                s1_w   = req_write[i];
                s1_a   = req_addr[i*AW +: AW];
                if (req_write[i]) begin
                    s1_d = req_wdata[i*DW +: DW];
                    ref_mem[s1_a] = s1_d;
                end else begin
                    rq.push_back('{due: cyc + 2, id: i, data: ref_mem[s1_a]});
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || resp_rdata !== '0 || sram_wen !== 1'b0 ||
            sram_ren !== 1'b0 || sram_wadr !== '0 || sram_radr !== '0 || sram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b rdata=%h wen=%b ren=%b wadr=%0d radr=%0d wdata=%h expected all 0",
                     req_ready, resp_valid, resp_rdata, sram_wen, sram_ren, sram_wadr, sram_radr, sram_wdata);
        end
`ifdef SRAM_ARB_STATS_EN
        checks++;
        if (grant_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counts: grant_cnt=%h expected 0", grant_cnt);
        end
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 1'b1, 10'd97, 128'd137);
        tick();
        idle();
        tick();
        set_req(0, 1'b1, 1'b0, 10'd97, '0);
        tick();
        idle();
        tick();
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 128'd137) begin
            errors++;
            $display("FAIL write_read: resp_valid=%b rdata=%0d expected 01 137", resp_valid, resp_rdata);
        end
        repeat (2) tick();
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_seq [4];
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;
        do_reset();
        set_req(0, 1'b1, 1'b1, 10'd83, 128'd84);
        set_req(1, 1'b1, 1'b1, 10'd4, 128'd39);
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++;
            if (req_ready !== exp_seq[t]) begin
                errors++;
                $display("FAIL contention_alt t=%0d: req_ready=%b expected %b", t, req_ready, exp_seq[t]);
            end
            tick();
        end
        set_req(0, 1'b1, 1'b0, 10'd83, '0);
        set_req(1, 1'b1, 1'b0, 10'd4, '0);
        repeat (2) tick();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        set_req(1, 1'b1, 1'b1, 10'd10, 128'd55);
        tick();
        idle();
        set_req(0, 1'b1, 1'b0, 10'd10, '0);
        tick();
        idle();
        tick();
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 128'd55) begin
            errors++;
            $display("FAIL back_to_back: resp_valid=%b rdata=%0d expected 01 55", resp_valid, resp_rdata);
        end
        repeat (2) tick();
    endtask

    task automatic test_starvation();
        int c0 = 0;
        int c1 = 0;
        int first1 = -1;
        for (int t = 0; t < 20; t++) begin
            set_req(0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
            set_req(1, t >= 5, 1'b0, AW'($urandom_range(0, 15)), '0);
            #1;
            if (t >= 5) begin
                if (req_ready[0]) c0++;
                if (req_ready[1]) begin
                    c1++;
                    if (first1 < 0) first1 = t;
                end
            end
            tick();
        end
        checks++;
        if (first1 < 0 || first1 > 6) begin
            errors++;
            $display("FAIL starvation_wait: first req1 grant at t=%0d expected <= 6", first1);
        end
        checks++;
        if (c0 - c1 > 1 || c1 - c0 > 1) begin
            errors++;
            $display("FAIL starvation_share: c0=%0d c1=%0d expected difference <= 1", c0, c1);
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_read();
        set_req(0, 1'b1, 1'b0, 10'd97, '0);
        tick();
        do_reset();
        repeat (4) tick();
        set_req(0, 1'b1, 1'b0, 10'd83, '0);
        set_req(1, 1'b1, 1'b0, 10'd4, '0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: req_ready=%b expected 01", req_ready);
        end
        tick();
        idle();
        repeat (3) tick();
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic test_stats();
        idle();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checks++;
        if (grant_cnt !== '0) begin
            errors++;
            $display("FAIL stats_clear_idle: grant_cnt=%h expected 0", grant_cnt);
        end
        set_req(0, 1'b1, 1'b1, 10'd200, rand_data());
        repeat (3) tick();
        idle();
        set_req(1, 1'b1, 1'b1, 10'd201, rand_data());
        repeat (2) tick();
        idle();
        tick();
        checks++;
        if (grant_cnt !== {16'd2, 16'd3}) begin
            errors++;
            $display("FAIL stats_count: grant_cnt=%h expected %h", grant_cnt, {16'd2, 16'd3});
        end
        set_req(0, 1'b1, 1'b1, 10'd202, rand_data());
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        idle();
        checks++;
        if (grant_cnt !== '0) begin
            errors++;
            $display("FAIL stats_clear_wins: grant_cnt=%h expected 0", grant_cnt);
        end
        repeat (3) tick();
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < NR; i++) begin
                set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 15)), rand_data());
            end
            tick();
        end
        idle();
        repeat (4) tick();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]     = '0;
            ref_mem[a] = '0;
        end
        cyc = 0;
        model_reset();
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
`ifdef SRAM_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
